// File: rtl/keccak_round_ctrl.sv
// Round sequencer for Keccak-f[1600]: owns the state register and steps the external round datapath once per cycle.
// Optional abort input is compiled in when KECCAK_ROUND_ABORT_EN is defined.
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int LANE_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [25*LANE_W-1:0]  in_data,
  output logic [25*LANE_W-1:0]  rnd_state,
  output logic [4:0]            rnd_index,
  input  logic [25*LANE_W-1:0]  rnd_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  out_data,
  output logic                  busy
`ifdef KECCAK_ROUND_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int         NUM_LANES  = 25;
  localparam int         STATE_W    = NUM_LANES * LANE_W;
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               fsm_reg;
  logic [4:0]         round_reg;
  logic [STATE_W-1:0] state_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               abort_in;
  logic               abort_req;
  logic               accept;

`ifdef KECCAK_ROUND_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // Abort only matters once a permutation is in flight; in IDLE it merely blocks the load.
  assign abort_req = abort_in && (fsm_reg != IDLE);

  // DONE hands its slot straight to the next input when downstream takes the result.
  assign in_ready = !abort_in && ((fsm_reg == IDLE) || ((fsm_reg == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam int HI = STATE_W - 1 - gi * LANE_W;
      always_ff @(posedge clk) begin
        if (rst || abort_req) begin
          state_reg[HI -: LANE_W] <= '0;
        end else if (accept) begin
          state_reg[HI -: LANE_W] <= in_data[HI -: LANE_W];
        end else if (fsm_reg == RUN) begin
          state_reg[HI -: LANE_W] <= rnd_result[HI -: LANE_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || abort_req) begin
      fsm_reg       <= IDLE;
      round_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      unique case (fsm_reg)
        IDLE: begin
          if (accept) begin
            fsm_reg   <= RUN;
            round_reg <= '0;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          if (round_reg == LAST_ROUND) begin
            fsm_reg       <= DONE;
            round_reg     <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            round_reg <= round_reg + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (accept) begin
              fsm_reg   <= RUN;
              round_reg <= '0;
              busy_reg  <= 1'b1;
            end else begin
              fsm_reg <= IDLE;
            end
          end
        end
        default: begin
          fsm_reg <= IDLE;
        end
      endcase
    end
  end

  assign rnd_state = state_reg;
  assign out_data  = state_reg;
  assign rnd_index = round_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule
